// File: rtl/alu_if.sv
// alu_if: instruction words in and registered R-type result out for the alu
interface alu_if;
  logic [31:0] Rtype;
  logic [31:0] Itype;
  logic [31:0] Y;
  modport master (output Rtype, output Itype, input Y);
  modport slave (input Rtype, input Itype, output Y);
endinterface

// File: rtl/alu.sv
// alu: 32-bit execute stage, R-type word writes rd and Y, I-type word writes rt; ports clk, rst_n (async active-low), bus (Rtype, Itype in; Y out)
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  logic [31:0] rf [32];
  logic [31:0] y, a, b, ia, se, ze, r_val, i_val;
  logic [5:0]  r_op, i_op;
  logic [4:0]  rs, rt, rd, sh, i_rs, i_rt;
  logic        r_ok, i_ok, unused_bits;
  assign r_op = bus.Rtype[31:26];
  assign rs = bus.Rtype[25:21];
  assign rt = bus.Rtype[20:16];
  assign rd = bus.Rtype[15:11];
  assign sh = bus.Rtype[10:6];
  assign unused_bits = ^bus.Rtype[5:0];
  assign i_op = bus.Itype[31:26];
  assign i_rs = bus.Itype[25:21];
  assign i_rt = bus.Itype[20:16];
  assign se = {{16{bus.Itype[15]}}, bus.Itype[15:0]};
  assign ze = {16'h0, bus.Itype[15:0]};
  assign a = rs == 5'd0 ? 32'h0 : rf[rs];
  assign b = rt == 5'd0 ? 32'h0 : rf[rt];
  assign ia = i_rs == 5'd0 ? 32'h0 : rf[i_rs];
  assign bus.Y = y;
  always_comb begin
    r_val = 32'h0;
    r_ok = 1'b1;
    case (r_op)
      6'd0:  r_val = a + b;
      6'd1:  r_val = a - b;
      6'd2:  r_val = a & b;
      6'd3:  r_val = a | b;
      6'd4:  r_val = a ^ b;
      6'd5:  r_val = ~(a | b);
      6'd6:  r_val = {31'h0, $signed(a) < $signed(b)};
      6'd10: r_val = b << sh;
      6'd11: r_val = b >> sh;
      default: r_ok = 1'b0;
    endcase
  end
  always_comb begin
    i_val = 32'h0;
    i_ok = 1'b1;
    case (i_op)
      6'd1: i_val = ia + se;
      6'd2: i_val = ia & ze;
      6'd3: i_val = ia | ze;
      6'd4: i_val = ia ^ ze;
      6'd5: i_val = {bus.Itype[15:0], 16'h0};
      6'd6: i_val = {31'h0, $signed(ia) < $signed(se)};
      default: i_ok = 1'b0;
    endcase
  end
  // the I-type write is issued last so it wins when both target the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      if (r_ok) y <= r_val;
      if (r_ok && rd != 5'd0) rf[rd] <= r_val;
      if (i_ok && i_rt != 5'd0) rf[i_rt] <= i_val;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed results for the alu
module tb_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] RN = {6'h3f, 26'h0};
  alu_if bus ();
  alu u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rw(input logic [5:0] op, input logic [4:0] s, t, d, sh);
    return {op, s, t, d, sh, 6'h0};
  endfunction
  function automatic logic [31:0] iw(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [31:0] r, input logic [31:0] i);
    bus.Rtype = r;
    bus.Itype = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] ops [9];
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd10, 6'd11};
    bus.Rtype = RN;
    bus.Itype = 32'h0;
    #2 rst_n = 1'b0;
    #1 check("reset_y", bus.Y, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    foreach (ops[k]) begin
      cyc(rw(ops[k], 0, 0, 0, 0), 32'h0);
      check($sformatf("zero_op%0d", ops[k]), bus.Y, ops[k] == 6'd5 ? 32'hffffffff : 32'h0);
    end
    cyc(RN, iw(1, 0, 1, 16'd5));
    check("itype_no_y", bus.Y, 32'h0);
    cyc(RN, iw(1, 0, 2, 16'd3));
    cyc(rw(0, 1, 2, 3, 0), 32'h0);
    check("add", bus.Y, 32'd8);
    cyc(rw(3, 3, 0, 0, 0), 32'h0);
    check("or_r3", bus.Y, 32'd8);
    cyc(rw(1, 1, 2, 0, 0), 32'h0);
    check("sub12", bus.Y, 32'd2);
    cyc(rw(1, 2, 1, 0, 0), 32'h0);
    check("sub21", bus.Y, 32'hfffffffe);
    cyc(rw(6, 2, 1, 0, 0), 32'h0);
    check("slt", bus.Y, 32'd1);
    cyc(RN, iw(1, 0, 5, 16'hffff));
    cyc(rw(6, 5, 0, 0, 0), 32'h0);
    check("slt_neg", bus.Y, 32'd1);
    cyc(RN, iw(5, 0, 6, 16'h8000));
    cyc(rw(0, 6, 6, 0, 0), 32'h0);
    check("add_wrap", bus.Y, 32'h0);
    cyc(rw(10, 0, 1, 0, 4), 32'h0);
    check("sll", bus.Y, 32'h50);
    cyc(rw(11, 0, 5, 0, 31), 32'h0);
    check("srl", bus.Y, 32'd1);
    cyc(rw(4, 1, 2, 0, 0), 32'h0);
    check("xor", bus.Y, 32'd6);
    cyc(rw(5, 1, 2, 0, 0), 32'h0);
    check("nor", bus.Y, 32'hfffffff8);
    cyc(rw(0, 1, 2, 4, 0), iw(1, 0, 4, 16'd9));
    check("both_y", bus.Y, 32'd8);
    cyc(rw(3, 4, 0, 0, 0), 32'h0);
    check("both_r4", bus.Y, 32'd9);
    cyc(rw(0, 1, 0, 0, 0), iw(1, 0, 1, 16'd100));
    check("old_r1", bus.Y, 32'd5);
    cyc(rw(3, 1, 0, 0, 0), 32'h0);
    check("new_r1", bus.Y, 32'd100);
    cyc(RN, iw(1, 0, 0, 16'd7));
    check("hold_itype", bus.Y, 32'd100);
    cyc(rw(3, 0, 0, 0, 0), 32'h0);
    check("r0_zero", bus.Y, 32'h0);
    cyc(rw(3, 1, 0, 0, 0), 32'h0);
    cyc(rw(6'h3f, 1, 2, 7, 3), 32'h0);
    check("undef_hold", bus.Y, 32'd100);
    cyc(rw(6'h07, 1, 2, 7, 0), 32'h0);
    check("undef7_hold", bus.Y, 32'd100);
    #2 rst_n = 1'b0;
    #1 check("async_rst_y", bus.Y, 32'h0);
    #1 rst_n = 1'b1;
    cyc(rw(3, 1, 5, 0, 0), 32'h0);
    check("rst_regs15", bus.Y, 32'h0);
    cyc(rw(0, 4, 6, 0, 0), 32'h0);
    check("rst_regs46", bus.Y, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
